// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter that owns a shared 1-bit data mux.
// An owner keeps the mux until it signals done, drops its request, or reaches MAX_HOLD cycles.
module rr_mux_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    input  logic [3:0] data,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       out,
    output logic       expired
);

    localparam int HW = $clog2(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic [HW-1:0] hold;
    logic          pick_valid;
    logic [1:0]    pick_idx;
    logic          at_limit;

    // Walk the search order backwards so the requester closest to ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                pick_valid = 1'b1;
                pick_idx   = ptr + 2'(k);
            end
        end
    end

    assign at_limit = (hold == HW'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= 4'b0000;
            sel     <= 2'b00;
            ptr     <= 2'b00;
            hold    <= '0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state <= GRANT;
                        grant <= 4'(1) << pick_idx;
                        sel   <= pick_idx;
                        ptr   <= pick_idx + 2'd1;
                        hold  <= '0;
                    end
                end
                GRANT: begin
                    // Every release passes through IDLE, so other requesters get a fair look.
                    if (done || !req[sel] || at_limit) begin
                        state   <= IDLE;
                        grant   <= 4'b0000;
                        hold    <= '0;
                        expired <= at_limit && !done && req[sel];
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == GRANT);
    assign out  = busy & data[sel];

endmodule
